// File: rtl/ifmap_frame_scheduler.sv
// Frame scheduler around the single-port ifmap BRAM: host LOAD, accelerator RUN, result latch.
// Optional RUN watchdog enabled by defining IFS_WATCHDOG_EN.
module ifmap_frame_scheduler #(
    parameter int FRAME_LEN   = 784,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              acc_read_en,
    input  logic [ADDR_W-1:0] acc_read_addr,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_data_valid,
    output logic              system_enable,
    input  logic [3:0]        final_out,
    input  logic              final_out_valid,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ARM,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_oob_q, rd_oob_d;
    logic [3:0]        result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              handshake;

`ifdef IFS_WATCHDOG_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    assign handshake = host_valid && (state_q == S_LOAD);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_valid_d     = 1'b0;
        rd_oob_d       = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
`ifdef IFS_WATCHDOG_EN
        wd_cnt_d       = wd_cnt_q;
        timeout_err_d  = timeout_err_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (handshake) begin
                    // wr_ptr==0 marks the first byte of a new frame
                    if (wr_ptr_q == '0) begin
                        result_valid_d = 1'b0;
`ifdef IFS_WATCHDOG_EN
                        timeout_err_d  = 1'b0;
`endif
                    end
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d = '0;
                        state_d  = S_ARM;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_ARM:   state_d = S_START;
            S_START: begin
                state_d = S_RUN;
`ifdef IFS_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            S_RUN: begin
                rd_valid_d = acc_read_en;
                rd_oob_d   = ({1'b0, acc_read_addr} >= FRAME_END);
                if (final_out_valid) begin
                    result_d       = final_out;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
`ifdef IFS_WATCHDOG_EN
                    timeout_err_d  = 1'b0;
                end else if (wd_cnt_q == WD_LAST) begin
                    result_d       = 4'hE;
                    result_valid_d = 1'b1;
                    timeout_err_d  = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
`endif
                end
            end
            S_DONE:  state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_LOAD;
            wr_ptr_q       <= '0;
            rd_valid_q     <= 1'b0;
            rd_oob_q       <= 1'b0;
            result_q       <= 4'hF;
            result_valid_q <= 1'b0;
`ifdef IFS_WATCHDOG_EN
            wd_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_valid_q     <= rd_valid_d;
            rd_oob_q       <= rd_oob_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
`ifdef IFS_WATCHDOG_EN
            wd_cnt_q       <= wd_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign host_ready     = (state_q == S_LOAD);
    assign system_enable  = (state_q == S_START);
    assign busy           = (state_q != S_LOAD);
    assign bram_we        = handshake;
    assign bram_din       = host_data;
    assign bram_addr      = (state_q == S_RUN) ? acc_read_addr : wr_ptr_q;
    assign acc_data_valid = rd_valid_q;
    assign acc_data       = (rd_valid_q && !rd_oob_q) ? bram_dout : '0;
    assign result         = result_q;
    assign result_valid   = result_valid_q;
`ifdef IFS_WATCHDOG_EN
    assign timeout_err    = timeout_err_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: doc/ifmap_frame_scheduler.md
# ifmap_frame_scheduler

- Sequences one inference per ifmap frame around the single-port ifmap BRAM.
- Owns the BRAM port and time-shares it between two requesters: the host byte stream (LOAD phase) and the accelerator's DRAM-style read port (RUN phase).
- Issues the one-cycle `system_enable` start pulse and latches the classification result.
- Sits between the board-level inputs and the accelerator top, replacing ad-hoc address muxing.

## Interface

Parameters:
- `FRAME_LEN`, 784: bytes per ifmap frame.
- `ADDR_W`, 10: BRAM address width; must satisfy 2^ADDR_W ≥ FRAME_LEN.
- `DATA_W`, 8: pixel width.
- `TIMEOUT_CYC`, 1048575: watchdog limit in RUN cycles (used only with `IFS_WATCHDOG_EN`).

Ports (one clock; reset is synchronous and active-high; clock port `clock`, reset port `reset`):
- `clock` in 1: system clock.
- `reset` in 1: synchronous active-high reset.
- `host_valid` in 1: host byte valid.
- `host_data` in DATA_W: host pixel byte.
- `host_ready` out 1: scheduler accepts a host byte this cycle.
- `acc_read_en` in 1: accelerator read request.
- `acc_read_addr` in ADDR_W: accelerator read address.
- `acc_data` out DATA_W: read data returned to the accelerator.
- `acc_data_valid` out 1: `acc_data` valid, one cycle after an accepted read.
- `system_enable` out 1: one-cycle start pulse to the accelerator.
- `final_out` in 4: accelerator class output.
- `final_out_valid` in 1: `final_out` qualifier.
- `result` out 4: latched class.
- `result_valid` out 1: `result` is from the most recent frame.
- `busy` out 1: high in every state except LOAD.
- `timeout_err` out 1: watchdog fired for the current frame.
- `bram_we` out 1: BRAM write enable.
- `bram_addr` out ADDR_W: BRAM address.
- `bram_din` out DATA_W: BRAM write data.
- `bram_dout` in DATA_W: BRAM read data, 1-cycle registered.

## Operation

States are LOAD, ARM, START, RUN and DONE. Reset enters LOAD.

- **LOAD**
  - `host_ready`=1.
  - A handshake (`host_valid`&`host_ready`) drives `bram_we`=1, `bram_addr`=wr_ptr, `bram_din`=`host_data` combinationally in the same cycle, and increments wr_ptr.
  - The first accepted byte of a frame clears `result_valid` and `timeout_err`.
  - A handshake with wr_ptr==FRAME_LEN-1 resets wr_ptr to 0 and moves to ARM.
  - Accelerator reads are ignored: no BRAM access, no `acc_data_valid`.
- **ARM**: one idle cycle. Moves to START.
- **START**: `system_enable`=1 for exactly this cycle. Moves to RUN.
- **RUN**
  - `host_ready`=0.
  - `bram_addr`=`acc_read_addr`, `bram_we`=0.
  - `acc_read_en` produces `acc_data_valid`=1 on the next cycle with `acc_data`=`bram_dout`.
  - For `acc_read_addr` ≥ FRAME_LEN, `acc_data`=0, still with valid.
  - `final_out_valid` latches `result`←`final_out`, sets `result_valid`=1 and moves to DONE.
- **DONE**: one cycle. Moves to LOAD; `busy` drops.

Boundary rules:
- `final_out_valid` outside RUN is ignored and `result` is unchanged.
- A read accepted in the last RUN cycle still returns its valid data in the following cycle.
- `host_valid` while `host_ready`=0 is not consumed; the host must hold the byte.
- `bram_addr` in idle cycles (LOAD with no handshake, ARM, START, DONE) is wr_ptr.

## Timing

- Reset values: `host_ready`=1 (state LOAD), `system_enable`=0, `acc_data_valid`=0, `acc_data`=0, `result`=4'hF, `result_valid`=0, `busy`=0, `timeout_err`=0, `bram_we`=0, wr_ptr=0.
- Last byte accepted at cycle T: ARM at T+1, `system_enable` at T+2, RUN from T+3.
- Read latency: exactly 1 cycle. One read per cycle, back-to-back.
- `final_out_valid` at cycle R: `result`/`result_valid` update at R+1 (DONE); `host_ready`=1 at R+2.
- Reset mid-frame: state, wr_ptr and all outputs return to reset values next cycle. BRAM contents are not cleared, and a partial frame is discarded.

## Configuration

- `IFS_WATCHDOG_EN` defined:
  - A cycle counter clears on entering RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYC without `final_out_valid`: `result`←4'hE, `result_valid`=1, `timeout_err`=1, and the state moves to DONE.
  - `final_out_valid` in that same cycle takes priority: normal result, `timeout_err`=0.
- Not defined: no counter; RUN waits indefinitely; `timeout_err` is tied to 0.

## Test plan

- Reset, then stream 784 bytes with `host_valid` held high → bytes 0..783 are written to addresses 0..783. `system_enable` pulses exactly once, 2 cycles after byte 783; `host_ready`=0 from then on.
- In RUN, reads at addr 0, 1, 783 and 800 back-to-back → `acc_data_valid` on the 4 following cycles with the stored bytes, then 0.
- In RUN, `final_out_valid` with `final_out`=4'd7 → `result`=7 and `result_valid`=1 next cycle; `host_ready`=1 one cycle later. A second frame's first byte clears `result_valid`.
- `final_out_valid`=1 with 4'd3 during LOAD, and reads during LOAD → `result` stays 4'hF and no `acc_data_valid`.
- Assert `reset` after 400 bytes → reset values restored. A full 784-byte frame then starts from address 0 and triggers a single `system_enable`.
- With `IFS_WATCHDOG_EN` and TIMEOUT_CYC=16, no `final_out_valid` → after 16 RUN cycles `result`=4'hE, `timeout_err`=1, and LOAD is re-entered.
